// File: rtl/pipeline_control_pkg.sv
// Shared opcode decode, FSM encoding and register-usage helpers for the
// four-stage pipeline sequencer.
package pipeline_control_pkg;

   localparam int unsigned OP_BITS  = 4;
   localparam int unsigned NREG_MAX = 8;

   typedef logic [OP_BITS-1:0]  op_t;
   typedef logic [NREG_MAX-1:0] reg_t;

   localparam op_t OP_LOAD  = 4'd0;
   localparam op_t OP_STOP  = 4'd1;
   localparam op_t OP_STORE = 4'd2;
   localparam op_t OP_ADD   = 4'd4;
   localparam op_t OP_BZ    = 4'd5;
   localparam op_t OP_SUB   = 4'd6;
   localparam op_t OP_NAND  = 4'd8;
   localparam op_t OP_BNZ   = 4'd9;
   localparam op_t OP_NOP   = 4'd10;
   localparam op_t OP_BPZ   = 4'd13;

   localparam logic [2:0] OP_LO_SHIFT = 3'd3;
   localparam logic [2:0] OP_LO_ORI   = 3'd7;

   localparam reg_t REG_K1 = 8'd1;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   typedef enum logic [3:0] {
      IC_LOAD,
      IC_STOP,
      IC_STORE,
      IC_ALU,
      IC_SHIFT,
      IC_ORI,
      IC_BRANCH,
      IC_NOP
   } iclass_t;

   // Low-3-bit SHIFT/ORI patterns win over the full 4-bit opcode table.
   function automatic iclass_t classify(input op_t op);
      iclass_t c;
      c = IC_NOP;
      if (op[2:0] == OP_LO_SHIFT) begin
         c = IC_SHIFT;
      end else if (op[2:0] == OP_LO_ORI) begin
         c = IC_ORI;
      end else begin
         case (op)
            OP_LOAD:                c = IC_LOAD;
            OP_STOP:                c = IC_STOP;
            OP_STORE:               c = IC_STORE;
            OP_ADD, OP_SUB, OP_NAND: c = IC_ALU;
            OP_BZ, OP_BNZ, OP_BPZ:  c = IC_BRANCH;
            default:                c = IC_NOP;
         endcase
      end
      return c;
   endfunction

   // ORI's implicit k1 source is reported through the ra path.
   function automatic logic reads_ra(input op_t op);
      iclass_t c;
      c = classify(op);
      return (c == IC_ALU) || (c == IC_STORE) || (c == IC_SHIFT) || (c == IC_ORI);
   endfunction

   function automatic logic reads_rb(input op_t op);
      iclass_t c;
      c = classify(op);
      return (c == IC_ALU) || (c == IC_LOAD) || (c == IC_STORE);
   endfunction

   function automatic logic writes_reg(input op_t op);
      iclass_t c;
      c = classify(op);
      return (c == IC_ALU) || (c == IC_LOAD) || (c == IC_SHIFT) || (c == IC_ORI);
   endfunction

   function automatic reg_t dest_of(input op_t op, input reg_t ra);
      return (classify(op) == IC_ORI) ? REG_K1 : ra;
   endfunction

   function automatic logic is_mem(input op_t op);
      iclass_t c;
      c = classify(op);
      return (c == IC_LOAD) || (c == IC_STORE);
   endfunction

   function automatic logic is_branch(input op_t op);
      return classify(op) == IC_BRANCH;
   endfunction

endpackage

// File: rtl/pipeline_control_if.sv
// Decode-field inputs and stage-control outputs between the sequencer
// (master) and the datapath (slave).
interface pipeline_control_if #(
   parameter int unsigned NREG_BITS = 2
);
   import pipeline_control_pkg::*;

   op_t                  r_op;
   logic [NREG_BITS-1:0] r_ra;
   logic [NREG_BITS-1:0] r_rb;
   logic                 branch_taken;

   logic pc_load;
   logic pc_sel;
   logic ir1_load;
   logic ir2_load;
   logic ir3_load;
   logic r1_sel;
   logic mem_sel;
   logic reg_write;
   logic x_valid;
   logic w_valid;
   logic stall;
   logic flush;
   logic halted;

   modport master (
      input  r_op, r_ra, r_rb, branch_taken,
      output pc_load, pc_sel, ir1_load, ir2_load, ir3_load, r1_sel, mem_sel,
             reg_write, x_valid, w_valid, stall, flush, halted
   );

   modport slave (
      output r_op, r_ra, r_rb, branch_taken,
      input  pc_load, pc_sel, ir1_load, ir2_load, ir3_load, r1_sel, mem_sel,
             reg_write, x_valid, w_valid, stall, flush, halted
   );

endinterface

// File: rtl/pipeline_control_hazard_detect.sv
// RAW hazard check: sources of the instruction in R against the pending
// destinations in X and, optionally, W.
module pipeline_control_hazard_detect
   import pipeline_control_pkg::*;
#(
   parameter bit          STALL_ON_WB = 1'b1,
   parameter int unsigned NREG_BITS   = 2
) (
   input  logic                 v_r,
   input  op_t                  r_op,
   input  logic [NREG_BITS-1:0] r_ra,
   input  logic [NREG_BITS-1:0] r_rb,
   input  logic                 v_x,
   input  logic                 x_wr,
   input  logic [NREG_BITS-1:0] x_dst,
   input  logic                 v_w,
   input  logic                 w_wr,
   input  logic [NREG_BITS-1:0] w_dst,
   output logic                 haz_c
);

   logic [NREG_BITS-1:0] src_a;
   logic                 use_a;
   logic                 use_b;
   logic                 hit_x;
   logic                 hit_w;

   always_comb begin
      src_a = NREG_BITS'(dest_of(r_op, NREG_MAX'(r_ra)));
      use_a = reads_ra(r_op);
      use_b = reads_rb(r_op);
      hit_x = v_x & x_wr & ((use_a & (src_a == x_dst)) | (use_b & (r_rb == x_dst)));
      hit_w = STALL_ON_WB & v_w & w_wr &
              ((use_a & (src_a == w_dst)) | (use_b & (r_rb == w_dst)));
      haz_c = v_r & (hit_x | hit_w);
   end

endmodule

// File: rtl/pipeline_control.sv
// Four-stage pipeline sequencer: stage valid tracking, PC/IR load enables,
// RAW and memory-port stalls, branch flush and STOP drain.
module pipeline_control
   import pipeline_control_pkg::*;
#(
   parameter bit          STALL_ON_WB = 1'b1,
   parameter int unsigned NREG_BITS   = 2
) (
   input logic                clock,
   input logic                reset,
   pipeline_control_if.master bus
);

   state_t               state;
   logic                 v_r;
   logic                 v_x;
   logic                 v_w;
   logic                 x_wr;
   logic                 w_wr;
   logic                 x_mem;
   logic                 x_br;
   logic [NREG_BITS-1:0] x_dst;
   logic [NREG_BITS-1:0] w_dst;

   iclass_t r_cls_c;
   logic    haz_c;
   logic    mem_busy_c;
   logic    adv_x_c;
   logic    v_r_nxt_c;
   state_t  state_nxt_c;

   logic pc_load_c;
   logic pc_sel_c;
   logic ir1_load_c;
   logic ir2_load_c;
   logic ir3_load_c;
   logic r1_sel_c;
   logic mem_sel_c;
   logic reg_write_c;
   logic x_valid_c;
   logic w_valid_c;
   logic stall_c;
   logic flush_c;
   logic halted_c;

   assign r_cls_c    = classify(bus.r_op);
   assign mem_busy_c = v_x & x_mem;

   pipeline_control_hazard_detect #(
      .STALL_ON_WB (STALL_ON_WB),
      .NREG_BITS   (NREG_BITS)
   ) u_hazard (
      .v_r   (v_r),
      .r_op  (bus.r_op),
      .r_ra  (bus.r_ra),
      .r_rb  (bus.r_rb),
      .v_x   (v_x),
      .x_wr  (x_wr),
      .x_dst (x_dst),
      .v_w   (v_w),
      .w_wr  (w_wr),
      .w_dst (w_dst),
      .haz_c (haz_c)
   );

   // Stage controls and next-state decisions; everything is forced low in reset.
   always_comb begin
      pc_load_c   = 1'b0;
      pc_sel_c    = 1'b0;
      ir1_load_c  = 1'b0;
      ir2_load_c  = 1'b0;
      ir3_load_c  = 1'b0;
      r1_sel_c    = 1'b0;
      mem_sel_c   = 1'b0;
      reg_write_c = 1'b0;
      x_valid_c   = 1'b0;
      w_valid_c   = 1'b0;
      stall_c     = 1'b0;
      flush_c     = 1'b0;
      halted_c    = 1'b0;
      adv_x_c     = 1'b0;
      v_r_nxt_c   = v_r;
      state_nxt_c = state;

      if (!reset) begin
         x_valid_c = v_x;
         w_valid_c = v_w;
         case (state)
            ST_RUN: begin
               ir3_load_c  = 1'b1;
               mem_sel_c   = mem_busy_c;
               reg_write_c = v_w & w_wr;
               r1_sel_c    = v_r & (r_cls_c == IC_ORI);
               if (v_x & x_br & bus.branch_taken) begin
                  flush_c   = 1'b1;
                  pc_load_c = 1'b1;
                  pc_sel_c  = 1'b1;
                  v_r_nxt_c = 1'b0;
               end else if (v_r & (r_cls_c == IC_STOP)) begin
                  state_nxt_c = ST_DRAIN;
                  v_r_nxt_c   = 1'b0;
               end else if (haz_c) begin
                  stall_c = 1'b1;
               end else begin
                  // A load/store in X owns the memory port, so nothing is fetched.
                  adv_x_c    = 1'b1;
                  ir2_load_c = 1'b1;
                  pc_load_c  = ~mem_busy_c;
                  ir1_load_c = ~mem_busy_c;
                  v_r_nxt_c  = ~mem_busy_c;
               end
            end
            ST_DRAIN: begin
               ir3_load_c  = 1'b1;
               mem_sel_c   = mem_busy_c;
               reg_write_c = v_w & w_wr;
               v_r_nxt_c   = 1'b0;
               if (!v_x && !v_w) begin
                  state_nxt_c = ST_HALTED;
               end
            end
            ST_HALTED: begin
               halted_c  = 1'b1;
               v_r_nxt_c = 1'b0;
            end
            default: begin
               state_nxt_c = ST_RUN;
               v_r_nxt_c   = 1'b0;
            end
         endcase
      end
   end

   // Pipeline bookkeeping: X takes R or a bubble, W always takes X.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_RUN;
         v_r   <= 1'b0;
         v_x   <= 1'b0;
         v_w   <= 1'b0;
         x_wr  <= 1'b0;
         w_wr  <= 1'b0;
         x_mem <= 1'b0;
         x_br  <= 1'b0;
         x_dst <= '0;
         w_dst <= '0;
      end else begin
         state <= state_nxt_c;
         v_r   <= v_r_nxt_c;
         v_w   <= v_x;
         w_wr  <= x_wr;
         w_dst <= x_dst;
         if (adv_x_c) begin
            v_x   <= v_r;
            x_wr  <= writes_reg(bus.r_op);
            x_dst <= NREG_BITS'(dest_of(bus.r_op, NREG_MAX'(bus.r_ra)));
            x_mem <= is_mem(bus.r_op);
            x_br  <= is_branch(bus.r_op);
         end else begin
            v_x   <= 1'b0;
            x_wr  <= 1'b0;
            x_mem <= 1'b0;
            x_br  <= 1'b0;
         end
      end
   end

   assign bus.pc_load   = pc_load_c;
   assign bus.pc_sel    = pc_sel_c;
   assign bus.ir1_load  = ir1_load_c;
   assign bus.ir2_load  = ir2_load_c;
   assign bus.ir3_load  = ir3_load_c;
   assign bus.r1_sel    = r1_sel_c;
   assign bus.mem_sel   = mem_sel_c;
   assign bus.reg_write = reg_write_c;
   assign bus.x_valid   = x_valid_c;
   assign bus.w_valid   = w_valid_c;
   assign bus.stall     = stall_c;
   assign bus.flush     = flush_c;
   assign bus.halted    = halted_c;

endmodule
